bwd_ctrl_pipe: RTL and testbench

Parametrised backward-extension control pipeline. It carries per-read control tokens (read number, status, i/j positions, k/l interval, sizes) through DEPTH register stages. It replaces the global `stall` with per-stage valid/ready flow control and adds per-read kill. The last stage issues either a BWT occurrence memory request (addr_k/addr_l) or a finish notification. It sits between the backward storage/curr-entry stages and the BWT memory request arbiter.

---
 rtl/bwd_ctrl_pipe_if.sv | 25 ++
 rtl/bwd_ctrl_pipe.sv | 173 +++++++++++++++++
 tb/tb_bwd_ctrl_pipe.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bwd_ctrl_pipe_if.sv
// Token stream between backward-extension stages: valid/ready plus per-read control fields.
interface bwd_ctrl_pipe_if #(
  parameter int READ_NUM_WIDTH = 8,
  parameter int POS_WIDTH      = 7
);
  logic                      valid;
  logic                      ready;
  logic [READ_NUM_WIDTH-1:0] read_num;
  logic [5:0]                status;
  logic [POS_WIDTH-1:0]      backward_i;
  logic [POS_WIDTH-1:0]      backward_j;
  logic [POS_WIDTH-1:0]      new_size;
  logic [63:0]               k;
  logic [63:0]               l;

  modport master (
    output valid, read_num, status, backward_i, backward_j, new_size, k, l,
    input  ready
  );

  modport slave (
    input  valid, read_num, status, backward_i, backward_j, new_size, k, l,
    output ready
  );
endinterface

// File: rtl/bwd_ctrl_pipe.sv
// DEPTH-stage control-token pipeline feeding the BWT occurrence request arbiter, with per-read kill.
// Latency DEPTH cycles input-to-output; combinational ready chain so bubbles collapse and a full stalled pipe drops in_ready.
module bwd_ctrl_pipe #(
  parameter int         READ_NUM_WIDTH = 8,
  parameter int         POS_WIDTH      = 7,
  parameter int         DEPTH          = 3,
  parameter int         K_SHIFT        = 7,
  parameter int         ADDR_WIDTH     = 42,
  parameter logic [5:0] FINISH_CODE    = 6'h3F
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  bwd_ctrl_pipe_if.slave            in_if,
  bwd_ctrl_pipe_if.master           out_if,
  input  logic                      kill_valid_i,
  input  logic [READ_NUM_WIDTH-1:0] kill_read_num_i,
  output logic                      request_valid_o,
  output logic [ADDR_WIDTH-1:0]     addr_k_o,
  output logic [ADDR_WIDTH-1:0]     addr_l_o,
  output logic                      finish_sign_o,
  output logic [POS_WIDTH-1:0]      mem_size_o,
  output logic                      query_valid_o,
  output logic [READ_NUM_WIDTH-1:0] query_read_num_o,
  output logic [POS_WIDTH-1:0]      next_query_position_o,
  output logic [3:0]                occupancy_o
);

  localparam int LAST = DEPTH - 1;

  typedef struct packed {
    logic [READ_NUM_WIDTH-1:0] read_num;
    logic [5:0]                status;
    logic [POS_WIDTH-1:0]      bwd_i;
    logic [POS_WIDTH-1:0]      bwd_j;
    logic [POS_WIDTH-1:0]      new_size;
    logic [63:0]               k;
    logic [63:0]               l;
  } tok_t;

  tok_t                      in_tok;
  tok_t                      tok_q [DEPTH];
  logic [DEPTH-1:0]          vld_q;
  logic [DEPTH-1:0]          vld_d;
  logic [DEPTH-1:0]          rdy_nx;
  logic [DEPTH-1:0]          mv;
  logic [DEPTH-1:0]          ld;
  logic [DEPTH-1:0]          kill_hit;
  logic [DEPTH-1:0]          kill_src;
  logic                      in_rdy;
  logic                      in_kill;
  logic [ADDR_WIDTH-1:0]     addr_k_q;
  logic [ADDR_WIDTH-1:0]     addr_l_q;
  logic [ADDR_WIDTH-1:0]     addr_k_d;
  logic [ADDR_WIDTH-1:0]     addr_l_d;
  logic                      query_vld_q;
  logic                      query_vld_d;
  logic [READ_NUM_WIDTH-1:0] query_rn_q;
  logic [POS_WIDTH-1:0]      query_pos_q;
  logic [POS_WIDTH-1:0]      query_pos_d;
  logic [3:0]                occ_q;
  logic [3:0]                occ_d;

  assign in_tok = '{
    read_num: in_if.read_num,
    status:   in_if.status,
    bwd_i:    in_if.backward_i,
    bwd_j:    in_if.backward_j,
    new_size: in_if.new_size,
    k:        in_if.k,
    l:        in_if.l
  };

  // rdy_nx[s] is the readiness of whatever sits after stage s; a stage is ready if
  // any stage from itself to the output is empty or the output is being taken.
  always_comb begin : ready_chain
    logic acc;
    acc    = out_if.ready;
    rdy_nx = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      rdy_nx[s] = acc;
      acc       = acc | ~vld_q[s];
    end
    in_rdy = acc;
  end

  // Kill never alters the ready chain: a killed token still moves, it just lands invalid.
  always_comb begin
    in_kill  = kill_valid_i && (in_if.read_num == kill_read_num_i);
    kill_hit = '0;
    mv       = '0;
    ld       = '0;
    kill_src = '0;
    vld_d    = '0;
    occ_d    = '0;
    for (int s = 0; s < DEPTH; s++) begin
      kill_hit[s] = kill_valid_i && vld_q[s] && (tok_q[s].read_num == kill_read_num_i);
      mv[s]       = vld_q[s] & rdy_nx[s];
    end
    ld[0]       = in_if.valid & in_rdy;
    kill_src[0] = in_kill;
    for (int s = 1; s < DEPTH; s++) begin
      ld[s]       = mv[s-1];
      kill_src[s] = kill_hit[s-1];
    end
    for (int s = 0; s < DEPTH; s++) begin
      vld_d[s] = ld[s] ? ~kill_src[s] : (vld_q[s] & ~mv[s] & ~kill_hit[s]);
      occ_d    = occ_d + {3'b000, vld_d[s]};
    end
  end

  assign addr_k_d    = tok_q[LAST-1].k[K_SHIFT +: ADDR_WIDTH];
  assign addr_l_d    = tok_q[LAST-1].l[K_SHIFT +: ADDR_WIDTH];
  assign query_pos_d = tok_q[LAST-1].bwd_i - POS_WIDTH'(1);
  assign query_vld_d = ld[LAST] && !kill_hit[LAST-1]
                       && (tok_q[LAST-1].bwd_i != '0)
                       && (tok_q[LAST-1].status != FINISH_CODE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      occ_q       <= '0;
      query_vld_q <= 1'b0;
      query_rn_q  <= '0;
      query_pos_q <= '0;
      addr_k_q    <= '0;
      addr_l_q    <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tok_q[s] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      occ_q       <= occ_d;
      query_vld_q <= query_vld_d;
      if (ld[0]) begin
        tok_q[0] <= in_tok;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (ld[s]) begin
          tok_q[s] <= tok_q[s-1];
        end
      end
      if (ld[LAST]) begin
        addr_k_q <= addr_k_d;
        addr_l_q <= addr_l_d;
      end
      if (query_vld_d) begin
        query_rn_q  <= tok_q[LAST-1].read_num;
        query_pos_q <= query_pos_d;
      end
    end
  end

  assign in_if.ready       = in_rdy;
  assign out_if.valid      = vld_q[LAST];
  assign out_if.read_num   = tok_q[LAST].read_num;
  assign out_if.status     = tok_q[LAST].status;
  assign out_if.backward_i = tok_q[LAST].bwd_i;
  assign out_if.backward_j = tok_q[LAST].bwd_j;
  assign out_if.new_size   = tok_q[LAST].new_size;
  assign out_if.k          = tok_q[LAST].k;
  assign out_if.l          = tok_q[LAST].l;

  assign request_valid_o       = vld_q[LAST] && (tok_q[LAST].status != FINISH_CODE);
  assign finish_sign_o         = vld_q[LAST] && (tok_q[LAST].status == FINISH_CODE);
  assign addr_k_o              = addr_k_q;
  assign addr_l_o              = addr_l_q;
  assign mem_size_o            = tok_q[LAST].new_size;
  assign query_valid_o         = query_vld_q;
  assign query_read_num_o      = query_rn_q;
  assign next_query_position_o = query_pos_q;
  assign occupancy_o           = occ_q;

endmodule

// File: tb/tb_bwd_ctrl_pipe.sv
// Directed bench for bwd_ctrl_pipe at DEPTH=3: streaming table plus backpressure, kill and mid-flight reset sequences.
module tb_bwd_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bwd_ctrl_pipe_if #(.READ_NUM_WIDTH(8), .POS_WIDTH(7)) in_if ();
  bwd_ctrl_pipe_if #(.READ_NUM_WIDTH(8), .POS_WIDTH(7)) out_if ();

  logic        kill_valid;
  logic [7:0]  kill_rn;
  logic        request_valid;
  logic [41:0] addr_k;
  logic [41:0] addr_l;
  logic        finish_sign;
  logic [6:0]  mem_size;
  logic        query_valid;
  logic [7:0]  query_rn;
  logic [6:0]  query_pos;
  logic [3:0]  occupancy;

  bwd_ctrl_pipe #(
    .READ_NUM_WIDTH(8), .POS_WIDTH(7), .DEPTH(3), .K_SHIFT(7),
    .ADDR_WIDTH(42), .FINISH_CODE(6'h3F)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .in_if                 (in_if),
    .out_if                (out_if),
    .kill_valid_i          (kill_valid),
    .kill_read_num_i       (kill_rn),
    .request_valid_o       (request_valid),
    .addr_k_o              (addr_k),
    .addr_l_o              (addr_l),
    .finish_sign_o         (finish_sign),
    .mem_size_o            (mem_size),
    .query_valid_o         (query_valid),
    .query_read_num_o      (query_rn),
    .next_query_position_o (query_pos),
    .occupancy_o           (occupancy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_tok(input logic v, input logic [7:0] rn, input logic [5:0] st,
                           input logic [6:0] bi, input logic [6:0] ns,
                           input logic [63:0] k, input logic [63:0] l);
    in_if.valid      = v;
    in_if.read_num   = rn;
    in_if.status     = st;
    in_if.backward_i = bi;
    in_if.backward_j = bi + 7'd1;
    in_if.new_size   = ns;
    in_if.k          = k;
    in_if.l          = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  rn;
    logic [5:0]  st;
    logic [6:0]  bi;
    logic [6:0]  ns;
    logic [63:0] k;
    logic [63:0] l;
    logic        e_ov;
    logic [7:0]  e_orn;
    logic        e_req;
    logic        e_fin;
    logic [41:0] e_ak;
    logic [41:0] e_al;
    logic [6:0]  e_ms;
    logic        e_qv;
    logic [6:0]  e_qp;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [7:0] rx [$];
    int         sent;
    int         seen;
    logic [63:0] k1;
    logic [63:0] l1;
    logic [63:0] ones;
    k1   = 64'h380;
    l1   = 64'h400;
    ones = '1;

    // iv rn st bi ns k l | ov orn req fin ak al ms qv qp occ
    vt[0]  = '{1'b1, 8'd1,  6'h00, 7'd9, 7'd21, k1, l1, 1'b0, 8'd0,  1'b0, 1'b0, 42'd0, 42'd0, 7'd0,  1'b0, 7'd0, 4'd0};
    vt[1]  = '{1'b1, 8'd2,  6'h00, 7'd0, 7'd22, k1, l1, 1'b0, 8'd0,  1'b0, 1'b0, 42'd0, 42'd0, 7'd0,  1'b0, 7'd0, 4'd1};
    vt[2]  = '{1'b1, 8'd3,  6'h00, 7'd5, 7'd23, k1, l1, 1'b0, 8'd0,  1'b0, 1'b0, 42'd0, 42'd0, 7'd0,  1'b0, 7'd0, 4'd2};
    vt[3]  = '{1'b1, 8'd4,  6'h00, 7'd1, 7'd24, k1, l1, 1'b1, 8'd1,  1'b1, 1'b0, 42'd7, 42'd8, 7'd21, 1'b1, 7'd8, 4'd3};
    vt[4]  = '{1'b1, 8'd5,  6'h00, 7'd3, 7'd25, k1, l1, 1'b1, 8'd2,  1'b1, 1'b0, 42'd7, 42'd8, 7'd22, 1'b0, 7'd0, 4'd3};
    vt[5]  = '{1'b1, 8'd9,  6'h3F, 7'd4, 7'd12, 64'h1_0080, ones,
               1'b1, 8'd3,  1'b1, 1'b0, 42'd7, 42'd8, 7'd23, 1'b1, 7'd4, 4'd3};
    vt[6]  = '{1'b1, 8'd10, 6'h01, 7'd1, 7'd3, 64'h7F, 64'h80,
               1'b1, 8'd4,  1'b1, 1'b0, 42'd7, 42'd8, 7'd24, 1'b1, 7'd0, 4'd3};
    vt[7]  = '{1'b0, 8'd0,  6'h00, 7'd0, 7'd0, 64'd0, 64'd0,
               1'b1, 8'd5,  1'b1, 1'b0, 42'd7, 42'd8, 7'd25, 1'b1, 7'd2, 4'd3};
    vt[8]  = '{1'b0, 8'd0,  6'h00, 7'd0, 7'd0, 64'd0, 64'd0,
               1'b1, 8'd9,  1'b0, 1'b1, 42'h201, 42'h3FF_FFFF_FFFF, 7'd12, 1'b0, 7'd0, 4'd2};
    vt[9]  = '{1'b0, 8'd0,  6'h00, 7'd0, 7'd0, 64'd0, 64'd0,
               1'b1, 8'd10, 1'b1, 1'b0, 42'd0, 42'd1, 7'd3,  1'b1, 7'd0, 4'd1};
    vt[10] = '{1'b0, 8'd0,  6'h00, 7'd0, 7'd0, 64'd0, 64'd0,
               1'b0, 8'd0,  1'b0, 1'b0, 42'd0, 42'd0, 7'd0,  1'b0, 7'd0, 4'd0};

    // Reset state
    rst_n        = 1'b0;
    kill_valid   = 1'b0;
    kill_rn      = 8'd0;
    out_if.ready = 1'b1;
    drive_tok(1'b0, 8'd0, 6'd0, 7'd0, 7'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    chk("rst in_ready",  64'(in_if.ready),   64'd1);
    chk("rst out_valid", 64'(out_if.valid),  64'd0);
    chk("rst request",   64'(request_valid), 64'd0);
    chk("rst finish",    64'(finish_sign),   64'd0);
    chk("rst query",     64'(query_valid),   64'd0);
    chk("rst occupancy", 64'(occupancy),     64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Streaming table
    for (int i = 0; i < 11; i++) begin
      drive_tok(vt[i].iv, vt[i].rn, vt[i].st, vt[i].bi, vt[i].ns, vt[i].k, vt[i].l);
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i),  64'(in_if.ready),   64'd1);
      chk($sformatf("row%0d out_valid", i), 64'(out_if.valid),  64'(vt[i].e_ov));
      chk($sformatf("row%0d request", i),   64'(request_valid), 64'(vt[i].e_req));
      chk($sformatf("row%0d finish", i),    64'(finish_sign),   64'(vt[i].e_fin));
      chk($sformatf("row%0d query_vld", i), 64'(query_valid),   64'(vt[i].e_qv));
      chk($sformatf("row%0d occupancy", i), 64'(occupancy),     64'(vt[i].e_occ));
      if (vt[i].e_ov) begin
        chk($sformatf("row%0d out_rn", i),   64'(out_if.read_num), 64'(vt[i].e_orn));
        chk($sformatf("row%0d addr_k", i),   64'(addr_k),          64'(vt[i].e_ak));
        chk($sformatf("row%0d addr_l", i),   64'(addr_l),          64'(vt[i].e_al));
        chk($sformatf("row%0d mem_size", i), 64'(mem_size),        64'(vt[i].e_ms));
      end
      if (vt[i].e_qv) begin
        chk($sformatf("row%0d query_pos", i), 64'(query_pos), 64'(vt[i].e_qp));
        chk($sformatf("row%0d query_rn", i),  64'(query_rn),  64'(vt[i].e_orn));
      end
      next_cycle();
    end

    // Backpressure: six offered with out_ready low, only three fit
    out_if.ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      drive_tok(1'b1, 8'(21 + sent), 6'h00, 7'd2, 7'd1, 64'd0, 64'd0);
      @(negedge clk);
      if (c == 3) chk("bp out_rn early", 64'(out_if.read_num), 64'd21);
      if (in_if.ready) sent++;
      next_cycle();
    end
    chk("bp accepted",  64'(sent),            64'd3);
    chk("bp in_ready",  64'(in_if.ready),     64'd0);
    chk("bp occupancy", 64'(occupancy),       64'd3);
    chk("bp out_valid", 64'(out_if.valid),    64'd1);
    chk("bp out_rn",    64'(out_if.read_num), 64'd21);
    chk("bp addr_k",    64'(addr_k),          64'd0);
    out_if.ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sent < 6) drive_tok(1'b1, 8'(21 + sent), 6'h00, 7'd2, 7'd1, 64'd0, 64'd0);
      else          drive_tok(1'b0, 8'd0, 6'h00, 7'd0, 7'd0, 64'd0, 64'd0);
      @(negedge clk);
      if (out_if.valid && out_if.ready) rx.push_back(out_if.read_num);
      if (in_if.valid && in_if.ready) sent++;
      next_cycle();
    end
    chk("bp delivered count", 64'(rx.size()), 64'd6);
    for (int j = 0; j < 6 && j < rx.size(); j++) begin
      chk($sformatf("bp order%0d", j), 64'(rx[j]), 64'(21 + j));
    end

    // Kill on a full stalled pipe holding reads 2, 7, 2
    out_if.ready = 1'b0;
    drive_tok(1'b1, 8'd2, 6'h00, 7'd3, 7'd1, 64'd0, 64'd0);
    next_cycle();
    drive_tok(1'b1, 8'd7, 6'h00, 7'd6, 7'd1, 64'd0, 64'd0);
    next_cycle();
    drive_tok(1'b1, 8'd2, 6'h00, 7'd3, 7'd1, 64'd0, 64'd0);
    next_cycle();
    drive_tok(1'b0, 8'd0, 6'h00, 7'd0, 7'd0, 64'd0, 64'd0);
    kill_valid = 1'b1;
    kill_rn    = 8'd2;
    @(negedge clk);
    chk("kill full in_ready", 64'(in_if.ready), 64'd0);
    chk("kill full occ",      64'(occupancy),   64'd3);
    next_cycle();
    kill_valid = 1'b0;
    @(negedge clk);
    chk("kill occ after",       64'(occupancy),    64'd1);
    chk("kill in_ready after",  64'(in_if.ready),  64'd1);
    chk("kill out_valid after", 64'(out_if.valid), 64'd0);
    out_if.ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("kill survivor valid", 64'(out_if.valid),    64'd1);
    chk("kill survivor rn",    64'(out_if.read_num), 64'd7);
    chk("kill survivor query", 64'(query_valid),     64'd1);
    chk("kill survivor qpos",  64'(query_pos),       64'd5);
    next_cycle();

    // Input token killed in its own acceptance cycle
    drive_tok(1'b1, 8'd3, 6'h00, 7'd4, 7'd1, 64'd0, 64'd0);
    kill_valid = 1'b1;
    kill_rn    = 8'd3;
    @(negedge clk);
    chk("inkill in_ready", 64'(in_if.ready), 64'd1);
    next_cycle();
    kill_valid = 1'b0;
    drive_tok(1'b0, 8'd0, 6'h00, 7'd0, 7'd0, 64'd0, 64'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_if.valid) seen++;
      next_cycle();
    end
    chk("inkill discarded", 64'(seen),      64'd0);
    chk("inkill occ",       64'(occupancy), 64'd0);

    // Reset asserted with two tokens in flight
    drive_tok(1'b1, 8'd40, 6'h00, 7'd2, 7'd1, 64'd0, 64'd0);
    next_cycle();
    drive_tok(1'b1, 8'd41, 6'h00, 7'd2, 7'd1, 64'd0, 64'd0);
    next_cycle();
    drive_tok(1'b0, 8'd0, 6'h00, 7'd0, 7'd0, 64'd0, 64'd0);
    next_cycle();
    chk("mid pre out_valid", 64'(out_if.valid), 64'd1);
    chk("mid pre occ",       64'(occupancy),    64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid out_valid", 64'(out_if.valid),  64'd0);
    chk("mid occ",       64'(occupancy),     64'd0);
    chk("mid request",   64'(request_valid), 64'd0);
    chk("mid in_ready",  64'(in_if.ready),   64'd1);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive_tok(1'b1, 8'd50, 6'h00, 7'd2, 7'd1, 64'd0, 64'd0);
      else        drive_tok(1'b0, 8'd0, 6'h00, 7'd0, 7'd0, 64'd0, 64'd0);
      @(negedge clk);
      chk($sformatf("post rst c%0d out_valid", c), 64'(out_if.valid), 64'(c == 3));
      if (c == 3) chk("post rst out_rn", 64'(out_if.read_num), 64'd50);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
